// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture/playback channel path.
package la_pkg;

  localparam int unsigned WORD_W      = 256;
  localparam int unsigned SUB_W       = 8;
  localparam int unsigned MAX_CH_LOG2 = 5;
  localparam int unsigned MAX_CH      = 1 << MAX_CH_LOG2;
  localparam int unsigned CH_W        = 3;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned TS_W        = 8;
  localparam int unsigned SHIFT_W     = 9;
  localparam int unsigned NSL_W       = 6;

  typedef logic [MAX_CH-1:0][SUB_W-1:0] ch_states_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              trig;
    logic [TS_W-1:0]   trig_sample;
  } pb_word_t;

  // Slices carried by one packed word; 0 marks an unsupported exponent.
  function automatic logic [NSL_W-1:0] slices_per_word(input logic [CH_W-1:0] c);
    if (c > CH_W'(MAX_CH_LOG2)) return '0;
    return NSL_W'(MAX_CH >> c);
  endfunction

  // Slice width in bits; 0 marks an unsupported exponent.
  function automatic logic [SHIFT_W-1:0] slice_bits(input logic [CH_W-1:0] c);
    if (c > CH_W'(MAX_CH_LOG2)) return '0;
    return SHIFT_W'(SUB_W << c);
  endfunction

endpackage

// File: rtl/playback_word_buffer.sv
// Two-entry word holding stage: cur (shiftable, being sliced) and nxt (staged).
module playback_word_buffer
  import la_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready_c,
  input  pb_word_t           in_word,
  input  logic               pop,
  input  logic               shift,
  input  logic [SHIFT_W-1:0] shift_w,
  output logic               cur_valid,
  output pb_word_t           cur_word,
  output logic               load_c
);

  logic     live;
  logic     nxt_valid;
  pb_word_t nxt_word;
  logic     in_fire;
  logic     cur_free;

  always_comb begin
    in_ready_c = live & ~nxt_valid;
    in_fire    = in_valid & in_ready_c;
    cur_free   = ~cur_valid | pop;
    load_c     = cur_free & (nxt_valid | in_fire);
  end

  // nxt is only written while cur is busy; a draining cur takes nxt or the input directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live      <= 1'b0;
      cur_valid <= 1'b0;
      cur_word  <= '0;
      nxt_valid <= 1'b0;
      nxt_word  <= '0;
    end else begin
      live <= 1'b1;
      if (cur_free) begin
        if (nxt_valid) begin
          cur_word  <= nxt_word;
          cur_valid <= 1'b1;
          nxt_valid <= 1'b0;
        end else if (in_fire) begin
          cur_word  <= in_word;
          cur_valid <= 1'b1;
        end else begin
          cur_valid <= 1'b0;
        end
      end else begin
        if (shift) cur_word.data <= cur_word.data << shift_w;
        if (in_fire) begin
          nxt_word  <= in_word;
          nxt_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/playback_channel_demapper.sv
// Unpacks 256-bit readback words into per-clock channel slices and regenerates
// the capture trigger marker on the matching slice.
module playback_channel_demapper
  import la_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   channels,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_trig,
  input  logic [TS_W-1:0]   in_trig_sample,
  output logic              out_valid,
  input  logic              out_ready,
  output ch_states_t        out_states,
  output logic              trig_out,
  output logic [2:0]        trig_pos,
  output logic              underrun,
  output logic              cfg_err
);

  pb_word_t           in_word;
  pb_word_t           cur_word;
  logic               cur_valid;
  logic               load_c;
  logic               pop;
  logic               shift;
  logic [CH_W-1:0]    c_q;
  logic [IDX_W-1:0]   idx;
  logic               run;
  logic               cfg_ok;
  logic [NSL_W-1:0]   n_sl;
  logic [IDX_W-1:0]   mask;
  logic [SHIFT_W-1:0] slice_w;
  logic               fire;
  logic               last;
  logic [WORD_W-1:0]  top_bits;

  assign in_word = '{data: in_data, trig: in_trig, trig_sample: in_trig_sample};

  playback_word_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready_c (in_ready),
    .in_word    (in_word),
    .pop        (pop),
    .shift      (shift),
    .shift_w    (slice_w),
    .cur_valid  (cur_valid),
    .cur_word   (cur_word),
    .load_c     (load_c)
  );

  // Slice selection, trigger match and flow control from the current word.
  always_comb begin
    cfg_ok    = (c_q <= CH_W'(MAX_CH_LOG2));
    n_sl      = slices_per_word(c_q);
    slice_w   = slice_bits(c_q);
    mask      = IDX_W'(n_sl - NSL_W'(1));
    last      = (idx == mask);
    out_valid = cur_valid & cfg_ok;
    fire      = out_valid & out_ready;
    // An illegal-config word is dropped the cycle after it loads.
    pop       = (fire & last) | (cur_valid & ~cfg_ok);
    shift     = fire & ~last;
    underrun  = run & out_ready & ~out_valid;
    trig_out  = out_valid & cur_word.trig &
                (((idx + IDX_W'(1)) & mask) == (cur_word.trig_sample[TS_W-1:3] & mask));
    trig_pos  = trig_out ? cur_word.trig_sample[2:0] : 3'b000;
    top_bits  = cur_word.data >> (SHIFT_W'(WORD_W) - slice_w);
    out_states = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (out_valid && (k < (32'd1 << c_q)))
        out_states[5'(k)] = top_bits[8'(SUB_W * k) +: SUB_W];
    end
  end

  // Per-word config latch, slice index, run tracking and sticky config error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      idx     <= '0;
      run     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (load_c) begin
        c_q <= channels;
        if (channels > CH_W'(MAX_CH_LOG2)) cfg_err <= 1'b1;
      end
      if (pop || load_c) idx <= '0;
      else if (fire)     idx <= idx + IDX_W'(1);
      if (fire) run <= 1'b1;
    end
  end

endmodule

// File: tb/tb_playback_channel_demapper.sv
// Directed bench with a slice-queue reference model for playback_channel_demapper.
module tb_playback_channel_demapper;
  import la_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   channels;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         in_trig;
  logic [7:0]   in_trig_sample;
  logic         out_valid;
  logic         out_ready;
  ch_states_t   out_states;
  logic         trig_out;
  logic [2:0]   trig_pos;
  logic         underrun;
  logic         cfg_err;

  always #5 clk = ~clk;

  playback_channel_demapper dut (
    .clk            (clk),
    .rst            (rst),
    .channels       (channels),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_trig        (in_trig),
    .in_trig_sample (in_trig_sample),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_states     (out_states),
    .trig_out       (trig_out),
    .trig_pos       (trig_pos),
    .underrun       (underrun),
    .cfg_err        (cfg_err)
  );

  typedef struct {
    logic [255:0] st;
    bit           trig;
    bit [2:0]     pos;
    bit           last;
  } slice_t;

  slice_t q[$];
  int     held;
  bit     live_m, run_m, cfg_m;
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected slice sequence of one word: slice j is the j-th W-bit field from the MSB end.
  function automatic void expand(input logic [255:0] w, input int c, input bit tr, input logic [7:0] ts);
    int wb, n;
    logic [255:0] sl, m;
    slice_t r;
    wb = 8 << c;
    n  = 256 / wb;
    m  = (wb == 256) ? {256{1'b1}} : ((256'(1) << wb) - 256'(1));
    for (int j = 0; j < n; j++) begin
      sl     = w >> (256 - (j + 1) * wb);
      r.st   = sl & m;
      r.trig = tr && (((j + 1) % n) == (int'(ts[7:3]) % n));
      r.pos  = ts[2:0];
      r.last = (j == n - 1);
      q.push_back(r);
    end
  endfunction

  always @(negedge clk) begin : compare
    bit ev, er, acc, popm;
    slice_t r;
    if (rst) begin
      q.delete();
      held = 0; live_m = 0; run_m = 0; cfg_m = 0;
    end
    ev = (q.size() > 0);
    er = live_m && (held < 2);
    chk("out_valid", 256'(out_valid), 256'(ev));
    chk("in_ready", 256'(in_ready), 256'(er));
    chk("cfg_err", 256'(cfg_err), 256'(cfg_m));
    chk("underrun", 256'(underrun), 256'(run_m && out_ready && !ev));
    if (ev) begin
      r = q[0];
      chk("out_states", 256'(out_states), r.st);
      chk("trig_out", 256'(trig_out), 256'(r.trig));
      if (r.trig) chk("trig_pos", 256'(trig_pos), 256'(r.pos));
    end else begin
      chk("idle_states", 256'(out_states), 256'(0));
      chk("idle_trig", 256'(trig_out), 256'(0));
    end
    if (!rst) begin
      acc  = in_valid && er;
      popm = ev && out_ready;
      if (popm) begin
        if (q[0].last) held--;
        void'(q.pop_front());
        run_m = 1;
      end
      if (acc) begin
        if (channels > 3'd5) cfg_m = 1;
        else begin
          expand(in_data, int'(channels), in_trig, in_trig_sample);
          held++;
        end
      end
      live_m = 1;
    end
  end

  task automatic offer_wait(input string name);
    bit got;
    got = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_accept actual=no_handshake expected=handshake", name);
    end
  endtask

  task automatic send(input logic [255:0] d, input bit tr, input logic [7:0] ts, input string name);
    in_data = d; in_trig = tr; in_trig_sample = ts; in_valid = 1;
    offer_wait(name);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (!out_valid && q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_drain actual=busy expected=idle", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [255:0] w1, wt, wa, wb, wc, wi, wr, wn;
    logic [255:0] w5 [4];
    int hits, hidx, hpos;

    rst = 1; channels = 0; in_valid = 0; in_data = '0; in_trig = 0;
    in_trig_sample = '0; out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_states", 256'(out_states), 256'(0));
    chk("rst_cfg_err", 256'(cfg_err), 256'(0));
    chk("rst_trig_pos", 256'(trig_pos), 256'(0));
    @(posedge clk); #1;
    rst = 0;

    // c=0: 32 single-channel slices, oldest byte first
    w1 = {8'h80, 240'h0, 8'h01};
    send(w1, 0, 8'h00, "c0");
    @(negedge clk);
    chk("c0_slice0", 256'(out_states), 256'h80);
    chk("c0_in_ready", 256'(in_ready), 256'(1));
    repeat (31) @(negedge clk);
    chk("c0_slice31", 256'(out_states), 256'h01);
    drain("c0");

    // c=5: one word per clock, back to back
    channels = 5;
    for (int i = 0; i < 4; i++) begin
      w5[i] = {8{32'h11223344 + 32'(i * 32'h01010101)}};
      send(w5[i], 0, 8'h00, "c5");
    end
    @(negedge clk);
    chk("c5_last_word", 256'(out_states), w5[3]);
    @(negedge clk);
    chk("c5_done", 256'(out_valid), 256'(0));
    drain("c5");

    // c=3: trigger at slice_ctr 2 lands on emitted slice 1, position 5
    channels = 3;
    wt = {4{64'h0123_4567_89AB_CDEF}};
    send(wt, 1, 8'b00010_101, "trig");
    hits = 0; hidx = -1; hpos = -1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (trig_out) begin hits++; hidx = j; hpos = int'(trig_pos); end
    end
    chk("trig_hits", 256'(hits), 256'(1));
    chk("trig_slice", 256'(hidx), 256'(1));
    chk("trig_pos_val", 256'(hpos), 256'(5));
    drain("trig");

    // c=4 backpressure: two words held, third stalls until cur drains
    channels = 4;
    out_ready = 0;
    wa = {16{16'hA5C3}} ^ {128'h0, {16{8'h11}}};
    wb = {32{8'h5B}};
    wc = {32{8'hE7}};
    send(wa, 0, 8'h00, "bp_a");
    send(wb, 0, 8'h00, "bp_b");
    in_data = wc; in_trig = 0; in_trig_sample = '0; in_valid = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      chk("bp_hold", 256'(out_states), {128'h0, wa[255:128]});
    end
    @(posedge clk); #1;
    out_ready = 1;
    offer_wait("bp_c");
    drain("bp");

    // illegal exponent: word dropped, sticky cfg_err
    channels = 6;
    wi = {32{8'h3C}};
    send(wi, 0, 8'h00, "illegal");
    @(negedge clk);
    chk("ill_valid", 256'(out_valid), 256'(0));
    chk("ill_cfg_err", 256'(cfg_err), 256'(1));
    repeat (4) @(negedge clk);
    chk("ill_cfg_sticky", 256'(cfg_err), 256'(1));
    @(posedge clk); #1;

    // reset mid-word at c=1, then a fresh word starts at its slice 0
    channels = 1;
    wr = {16{16'hBEEF}};
    send(wr, 0, 8'h00, "pre_rst");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rst_mid_valid", 256'(out_valid), 256'(0));
    chk("rst_mid_ready", 256'(in_ready), 256'(0));
    chk("rst_mid_cfg", 256'(cfg_err), 256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    wn = {8'h9A, 8'h42, 240'h0};
    send(wn, 0, 8'h00, "post_rst");
    @(negedge clk);
    chk("post_rst_slice0", 256'(out_states), 256'h9A42);
    chk("post_rst_underrun", 256'(underrun), 256'(0));
    drain("post_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
